// File: rtl/miriscv_execute_pipe_buf.sv
// miriscv_execute_pipe_buf
// Execute-to-memory skid buffer: a small circular FIFO between the execute
// stage and the memory stage. The control unit can flush it with kill_i and
// receives a stall request when execute offers data the buffer cannot take.
// Head data is masked to zero whenever the buffer is empty, so storage
// itself never needs a reset.

module miriscv_execute_pipe_buf #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clk_i,
   input  logic              arstn_i,
   input  logic              kill_i,
   input  logic              d_valid_i,
   input  logic [DATA_W-1:0] d_data_i,
   output logic              d_ready_o,
   output logic              m_valid_o,
   output logic [DATA_W-1:0] m_data_o,
   input  logic              m_ready_i,
   output logic              stall_req_o,
   output logic [CNT_W-1:0]  count_o
);

   // DEPTH is a power of two, so a PTR_W-bit pointer wraps modulo DEPTH
   // on its own with no compare-and-clear logic.
   localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;

   logic              push;
   logic              pop;

   // Handshake decode; ready/valid depend only on occupancy so d_ready_o
   // never combinationally follows m_ready_i.
   always_comb begin
      d_ready_o   = (count != FULL_CNT);
      m_valid_o   = (count != '0);
      push        = d_valid_i & d_ready_o & ~kill_i;
      pop         = m_valid_o & m_ready_i & ~kill_i;
      stall_req_o = d_valid_i & ~d_ready_o & ~kill_i;
      m_data_o    = m_valid_o ? mem[rd_ptr] : '0;
      count_o     = count;
   end

   // Write pointer: cleared by reset or kill, advances on every push.
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         wr_ptr <= '0;
      end else if (kill_i) begin
         wr_ptr <= '0;
      end else if (push) begin
         wr_ptr <= wr_ptr + PTR_W'(1);
      end
   end

   // Read pointer: cleared by reset or kill, advances on every pop.
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         rd_ptr <= '0;
      end else if (kill_i) begin
         rd_ptr <= '0;
      end else if (pop) begin
         rd_ptr <= rd_ptr + PTR_W'(1);
      end
   end

   // Occupancy: +1 on push alone, -1 on pop alone, unchanged on both.
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         count <= '0;
      end else if (kill_i) begin
         count <= '0;
      end else begin
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Payload storage; contents are don't-care until written, and the
   // output mask keeps unwritten entries invisible.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr] <= d_data_i;
      end
   end

endmodule

// File: tb/tb_miriscv_execute_pipe_buf.sv
// tb_miriscv_execute_pipe_buf
// Directed bench for the execute/memory pipe buffer with DATA_W=8, DEPTH=2.
// Inputs change 1 ns after each rising edge; outputs are checked there too.

module tb_miriscv_execute_pipe_buf;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 2;
   localparam int CNT_W  = $clog2(DEPTH + 1);

   logic              clk_i;
   logic              arstn_i;
   logic              kill_i;
   logic              d_valid_i;
   logic [DATA_W-1:0] d_data_i;
   logic              d_ready_o;
   logic              m_valid_o;
   logic [DATA_W-1:0] m_data_o;
   logic              m_ready_i;
   logic              stall_req_o;
   logic [CNT_W-1:0]  count_o;

   int checks   = 0;
   int failures = 0;

   miriscv_execute_pipe_buf #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH)
   ) dut (
      .clk_i      (clk_i),
      .arstn_i    (arstn_i),
      .kill_i     (kill_i),
      .d_valid_i  (d_valid_i),
      .d_data_i   (d_data_i),
      .d_ready_o  (d_ready_o),
      .m_valid_o  (m_valid_o),
      .m_data_o   (m_data_o),
      .m_ready_i  (m_ready_i),
      .stall_req_o(stall_req_o),
      .count_o    (count_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // advance to 1 ns after the next rising edge
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic push_one(input logic [7:0] v);
      d_valid_i = 1'b1;
      d_data_i  = v;
      step();
      d_valid_i = 1'b0;
   endtask

   initial begin
      arstn_i   = 1'b0;
      kill_i    = 1'b0;
      d_valid_i = 1'b0;
      d_data_i  = '0;
      m_ready_i = 1'b0;

      // reset state
      #3;
      chk("rst_m_valid", 32'(m_valid_o), 32'd0);
      chk("rst_m_data",  32'(m_data_o),  32'h00);
      chk("rst_d_ready", 32'(d_ready_o), 32'd1);
      chk("rst_stall",   32'(stall_req_o), 32'd0);
      chk("rst_count",   32'(count_o),   32'd0);
      @(posedge clk_i);
      @(negedge clk_i);
      arstn_i = 1'b1;
      chk("post_rst_count", 32'(count_o), 32'd0);
      chk("post_rst_ready", 32'(d_ready_o), 32'd1);

      // single push, first edge after reset release
      push_one(8'hA1);
      chk("p1_m_valid", 32'(m_valid_o), 32'd1);
      chk("p1_m_data",  32'(m_data_o),  32'hA1);
      chk("p1_count",   32'(count_o),   32'd1);
      chk("p1_d_ready", 32'(d_ready_o), 32'd1);
      m_ready_i = 1'b1;
      step();
      m_ready_i = 1'b0;
      chk("p1_drain_count", 32'(count_o), 32'd0);
      chk("p1_drain_data",  32'(m_data_o), 32'h00);

      // back-to-back fill, stall while 0x33 is held
      d_valid_i = 1'b1;
      d_data_i  = 8'h11;
      step();
      d_data_i  = 8'h22;
      step();
      d_data_i  = 8'h33;
      #1;
      chk("fill_count",   32'(count_o),     32'd2);
      chk("fill_d_ready", 32'(d_ready_o),   32'd0);
      chk("fill_stall",   32'(stall_req_o), 32'd1);
      step();
      chk("hold_count",   32'(count_o),     32'd2);
      chk("hold_head",    32'(m_data_o),    32'h11);
      m_ready_i = 1'b1;
      step();
      chk("ord_head1",  32'(m_data_o), 32'h22);
      chk("ord_count1", 32'(count_o),  32'd1);
      step();
      d_valid_i = 1'b0;
      chk("ord_head2",  32'(m_data_o), 32'h33);
      chk("ord_count2", 32'(count_o),  32'd1);
      step();
      chk("ord_empty",  32'(count_o),  32'd0);

      // streaming with pointer wrap, no bubbles
      m_ready_i = 1'b1;
      d_valid_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         d_data_i = 8'(i);
         step();
         chk($sformatf("stream_data%0d", i),  32'(m_data_o),  32'(i));
         chk($sformatf("stream_count%0d", i), 32'(count_o),   32'd1);
         chk($sformatf("stream_valid%0d", i), 32'(m_valid_o), 32'd1);
      end
      d_valid_i = 1'b0;
      step();
      m_ready_i = 1'b0;
      chk("stream_end_count", 32'(count_o), 32'd0);

      // kill on a full buffer discards everything, including a concurrent push
      push_one(8'h55);
      push_one(8'h66);
      chk("kill_pre_count", 32'(count_o), 32'd2);
      d_valid_i = 1'b1;
      d_data_i  = 8'h77;
      kill_i    = 1'b1;
      #1;
      chk("kill_stall_masked", 32'(stall_req_o), 32'd0);
      step();
      kill_i    = 1'b0;
      d_valid_i = 1'b0;
      chk("kill_count",   32'(count_o),   32'd0);
      chk("kill_m_valid", 32'(m_valid_o), 32'd0);
      chk("kill_m_data",  32'(m_data_o),  32'h00);
      chk("kill_d_ready", 32'(d_ready_o), 32'd1);
      push_one(8'hAB);
      chk("kill_after_head",  32'(m_data_o), 32'hAB);
      chk("kill_after_count", 32'(count_o),  32'd1);
      m_ready_i = 1'b1;
      step();
      m_ready_i = 1'b0;
      chk("kill_after_drain", 32'(count_o), 32'd0);

      // full buffer: pop proceeds, push waits one cycle
      push_one(8'h41);
      push_one(8'h42);
      m_ready_i = 1'b1;
      d_valid_i = 1'b1;
      d_data_i  = 8'h99;
      #1;
      chk("full_stall", 32'(stall_req_o), 32'd1);
      step();
      m_ready_i = 1'b0;
      chk("full_pop_count", 32'(count_o),  32'd1);
      chk("full_pop_head",  32'(m_data_o), 32'h42);
      step();
      d_valid_i = 1'b0;
      chk("full_push_count", 32'(count_o), 32'd2);
      m_ready_i = 1'b1;
      step();
      chk("full_ord_head", 32'(m_data_o), 32'h99);
      step();
      m_ready_i = 1'b0;
      chk("full_ord_empty", 32'(count_o), 32'd0);

      // asynchronous reset mid-cycle with a full buffer
      push_one(8'h10);
      push_one(8'h20);
      chk("arst_pre_count", 32'(count_o), 32'd2);
      #2;
      arstn_i = 1'b0;
      #1;
      chk("arst_count",   32'(count_o),   32'd0);
      chk("arst_m_valid", 32'(m_valid_o), 32'd0);
      chk("arst_m_data",  32'(m_data_o),  32'h00);
      chk("arst_d_ready", 32'(d_ready_o), 32'd1);
      @(posedge clk_i);
      @(negedge clk_i);
      arstn_i = 1'b1;
      chk("arst_rel_valid", 32'(m_valid_o), 32'd0);
      push_one(8'h3C);
      chk("arst_push_data",  32'(m_data_o), 32'h3C);
      chk("arst_push_count", 32'(count_o),  32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/miriscv_execute_pipe_buf.md
MIRISCV_EXECUTE_PIPE_BUF -- requirements
Module: miriscv_execute_pipe_buf

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the payload width in bits (>=1).
REQ-002 The block SHALL have parameter DEPTH, default 2, giving the entry count (power of two, >=2).
REQ-003 The block SHALL have localparam CNT_W = $clog2(DEPTH+1), giving the occupancy counter width.
REQ-004 Port clk_i, input, 1, SHALL be the clock; all state updates on its rising edge.
REQ-005 Port arstn_i, input, 1, SHALL be the asynchronous, active-low reset.
REQ-006 Port kill_i, input, 1, SHALL be the flush request from the control unit.
REQ-007 Port d_valid_i, input, 1, SHALL be execute-side payload valid.
REQ-008 Port d_data_i, input, DATA_W, SHALL be the execute-side payload.
REQ-009 Port d_ready_o, output, 1, SHALL be buffer-can-accept.
REQ-010 Port m_valid_o, output, 1, SHALL be memory-side payload valid.
REQ-011 Port m_data_o, output, DATA_W, SHALL be the memory-side payload (head entry).
REQ-012 Port m_ready_i, input, 1, SHALL be memory-side accept.
REQ-013 Port stall_req_o, output, 1, SHALL be the stall request to the control unit.
REQ-014 Port count_o, output, CNT_W, SHALL be the current occupancy.

Function
REQ-015 Storage SHALL be a circular FIFO of DEPTH entries with write pointer, read pointer and occupancy counter.
REQ-016 Push SHALL occur when d_valid_i & d_ready_o & ~kill_i.
REQ-017 Pop SHALL occur when m_valid_o & m_ready_i & ~kill_i.
REQ-018 d_ready_o SHALL be (count_o != DEPTH), combinational from state only, never from m_ready_i.
REQ-019 m_valid_o SHALL be (count_o != 0).
REQ-020 m_data_o SHALL equal the entry at the read pointer when m_valid_o=1, else all zeros.
REQ-021 On push, d_data_i SHALL be written at the write pointer, which then increments modulo DEPTH.
REQ-022 On pop, the read pointer SHALL increment modulo DEPTH.
REQ-023 Count SHALL update +1 on push only, -1 on pop only, and stay unchanged on simultaneous push and pop.
REQ-024 Simultaneous push and pop when full SHALL NOT occur, because d_ready_o=0; the pop proceeds and the push waits.
REQ-025 Simultaneous push and pop when empty SHALL NOT occur, because m_valid_o=0; the push proceeds.
REQ-026 Latency SHALL be one cycle: data pushed at edge N appears on m_data_o with m_valid_o=1 after edge N.
REQ-027 Ordering SHALL be strict FIFO, with no reordering, duplication or loss absent kill_i.
REQ-028 kill_i=1 at an edge SHALL set count, write pointer and read pointer to 0 and discard any concurrent push/pop.
REQ-029 kill_i SHALL have priority over push and pop.
REQ-030 stall_req_o SHALL be d_valid_i & ~d_ready_o & ~kill_i.
REQ-031 Pointer wrap SHALL be seamless: after DEPTH pushes and pops, the pointers return to 0 with no bubble.
REQ-032 Storage entries SHALL NOT require reset; outputs SHALL never expose unreset storage because of REQ-020.

Reset
REQ-033 arstn_i=0 SHALL asynchronously force count, write pointer and read pointer to 0.
REQ-034 During and after reset: m_valid_o=0, m_data_o=0, d_ready_o=1, stall_req_o=0, count_o=0.
REQ-035 Reset asserted mid-operation SHALL discard all entries immediately, with no partial pop visible after deassertion.
REQ-036 The first push SHALL be allowed at the first rising edge after arstn_i deasserts.

Verification (DATA_W=8, DEPTH=2)
REQ-037 Reset, push 0xA1 with m_ready_i=0 -> next cycle m_valid_o=1, m_data_o=0xA1, count_o=1, d_ready_o=1.
REQ-038 Push 0x11, 0x22, 0x33 back-to-back, m_ready_i=0 -> after two pushes count_o=2, d_ready_o=0, stall_req_o=1 while 0x33 is held; raise m_ready_i -> outputs 0x11, 0x22, 0x33 in order.
REQ-039 Continuous push and pop with m_ready_i=1 over 10 values 0x00..0x09 -> each appears one cycle after push, count_o stays 1, pointers wrap, no bubble.
REQ-040 Full buffer (0x55, 0x66) with push 0x77 and kill_i=1 in the same cycle -> next cycle count_o=0, m_valid_o=0, m_data_o=0x00, d_ready_o=1; 0x77 not stored.
REQ-041 Full buffer with m_ready_i=1 and d_valid_i=1 (0x99) -> pop of head occurs, 0x99 not accepted that cycle, count_o=1; accepted next cycle, count_o=2.
REQ-042 Assert arstn_i=0 mid-cycle with count_o=2 -> immediately count_o=0, m_valid_o=0, m_data_o=0; after release, push 0x3C -> m_data_o=0x3C one cycle later.
